pif_regbank: RTL



---
 rtl/pif_regbank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pif_regbank.sv
// PIF host register bank: ID word, scratch file, control register and registered read mux.
// Define PIF_COUNTER_EN to build the free-running counter with read snapshot at address 3.
module pif_regbank #(
    parameter logic [31:0] ID_WORD       = 32'h50494631,
    parameter int          TXA           = 2,
    parameter int          TXSubA        = 2,
    parameter int          I2C_DATA_BITS = 6,
    parameter int          XSUBA_MAX     = 3
) (
    input  logic                     xclk,
    input  logic                     rst,
    input  logic                     XI_PWr,
    input  logic [TXA:0]             XI_PRWA,
    input  logic                     XI_PRdFinished,
    input  logic [TXSubA:0]          XI_PRdSubA,
    input  logic [I2C_DATA_BITS-1:0] XI_PD,
    output logic [7:0]               XO,
    output logic [I2C_DATA_BITS-1:0] ctrl,
    output logic [TXSubA:0]          wr_suba
);

    localparam logic [TXA:0] AddrId      = (TXA+1)'(0);
    localparam logic [TXA:0] AddrScratch = (TXA+1)'(1);
    localparam logic [TXA:0] AddrCtrl    = (TXA+1)'(2);
`ifdef PIF_COUNTER_EN
    localparam logic [TXA:0] AddrCnt     = (TXA+1)'(3);
`endif

    logic [TXA:0]             prev_prwa;
    logic [I2C_DATA_BITS-1:0] scratch [4];

    logic                     addrChg;
    logic [TXSubA:0]          wrSubEff;
    logic [TXSubA:0]          wrSubInc;
    logic [TXSubA:0]          wrSubNext;
    logic                     wrScratch;
    logic                     wrCtrl;
    logic [1:0]               rdIdx;
    logic                     rdInRange;
    logic [7:0]               xoD;
    logic                     unusedRdFinished;

    // Read-byte completion is tracked upstream; nothing here depends on it.
    assign unusedRdFinished = XI_PRdFinished;

`ifdef PIF_COUNTER_EN
    logic [31:0] cnt;
    logic [31:0] snap;
    logic        cntClr;

    assign cntClr = XI_PWr && (XI_PRWA == AddrCnt) && (wrSubEff == '0);

    always_ff @(posedge xclk) begin
        if (rst) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cntClr ? '0 : cnt + 32'd1;
            // Holding sub 0 keeps refreshing; later bytes then read a frozen copy.
            if ((XI_PRWA == AddrCnt) && (XI_PRdSubA == '0)) begin
                snap <= cnt;
            end
        end
    end
`endif

    always_comb begin
        addrChg   = (XI_PRWA != prev_prwa);
        // A fresh address starts its burst at sub 0, even for a write in that same cycle.
        wrSubEff  = addrChg ? '0 : wr_suba;
        wrSubInc  = (int'(wrSubEff) >= XSUBA_MAX) ? '0 : wrSubEff + 1'b1;
        wrSubNext = XI_PWr ? wrSubInc : wrSubEff;
        wrScratch = XI_PWr && (XI_PRWA == AddrScratch) && (int'(wrSubEff) < 4);
        wrCtrl    = XI_PWr && (XI_PRWA == AddrCtrl);
    end

    always_comb begin
        rdIdx     = XI_PRdSubA[1:0];
        rdInRange = (int'(XI_PRdSubA) < 4);
        xoD       = '0;
        case (XI_PRWA)
            AddrId: begin
                if (rdInRange) begin
                    xoD = ID_WORD[{rdIdx, 3'b000} +: 8];
                end
            end
            AddrScratch: begin
                if (rdInRange) begin
                    xoD = 8'(scratch[rdIdx]);
                end
            end
            AddrCtrl: begin
                xoD = 8'(ctrl);
            end
`ifdef PIF_COUNTER_EN
            AddrCnt: begin
                if (rdInRange) begin
                    xoD = snap[{rdIdx, 3'b000} +: 8];
                end
            end
`endif
            default: begin
                xoD = '0;
            end
        endcase
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            XO        <= '0;
            ctrl      <= '0;
            wr_suba   <= '0;
            prev_prwa <= '0;
            for (int i = 0; i < 4; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            XO        <= xoD;
            prev_prwa <= XI_PRWA;
            wr_suba   <= wrSubNext;
            if (wrCtrl) begin
                ctrl <= XI_PD;
            end
            if (wrScratch) begin
                scratch[wrSubEff[1:0]] <= XI_PD;
            end
        end
    end

endmodule
